// File: rtl/sdram_size_probe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sdram_size_probe
//  Brief    : Post-ready SDRAM size probe (alias-sensitive write/read-back),
//             then a continuous background zero-fill of the whole array.
//  Revision : 1.0
// ============================================================================

module sdram_size_probe #(
  parameter int CLR_AW  = 25,
  parameter int CLR_GAP = 32,
  parameter int TIMEOUT = 4095
) (
  input  logic        i_clk_sys,
  input  logic        i_reset,
  input  logic        i_sd_ready,
  input  logic [15:0] i_sd_dout,
  output logic [26:0] o_sd_addr,
  output logic [15:0] o_sd_din,
  output logic        o_sd_we,
  output logic        o_sd_rd,
  output logic [15:0] o_cfg,
  output logic        o_pass_done
);

  localparam int c_GAP_W = $clog2(CLR_GAP);
  localparam int c_TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [3:0] S_WAIT = 4'd0;
  localparam logic [3:0] S_W0   = 4'd1;
  localparam logic [3:0] S_W1   = 4'd2;
  localparam logic [3:0] S_W2   = 4'd3;
  localparam logic [3:0] S_W3   = 4'd4;
  localparam logic [3:0] S_R0   = 4'd5;
  localparam logic [3:0] S_R1   = 4'd6;
  localparam logic [3:0] S_R2   = 4'd7;
  localparam logic [3:0] S_FIN  = 4'd8;
  localparam logic [3:0] S_FILL = 4'd9;

  logic [3:0]         r_state;
  logic [3:0]         w_state_nxt;
  logic               r_we;
  logic               r_rd;
  logic [26:0]        r_addr;
  logic [15:0]        r_din;
  logic [15:0]        r_cfg;
  logic               r_wrap;
  logic               r_pass;
  logic [c_GAP_W-1:0] r_cnt;
  logic [CLR_AW-1:0]  r_faddr;
  logic [c_TO_W-1:0]  r_tcnt;

  logic               w_probe;
  logic               w_ok;
  logic               w_wait;
  logic               w_tout;
  logic               w_fill_wr;
  logic               w_we;
  logic               w_rd;
  logic [26:0]        w_addr;
  logic [15:0]        w_din;
  logic [15:0]        w_cfg;

  // The cycle a strobe is on the bus is the dead cycle: ready is ignored there.
  assign w_probe   = (r_state >= S_W0) && (r_state <= S_FIN);
  assign w_ok      = i_sd_ready && !(r_we || r_rd);
  assign w_wait    = !i_sd_ready && !(r_we || r_rd);
  assign w_tout    = w_probe && w_wait && (r_tcnt == c_TO_W'(TIMEOUT - 1));
  assign w_fill_wr = (r_state == S_FILL) && (r_cnt == c_GAP_W'(CLR_GAP - 1)) && i_sd_ready;

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) r_state <= S_WAIT;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT: if (i_sd_ready) w_state_nxt = S_W0;
      S_W0, S_W1, S_W2, S_W3, S_R0, S_R1, S_R2: begin
        if (w_ok)        w_state_nxt = r_state + 4'd1;
        else if (w_tout) w_state_nxt = S_FILL;
      end
      S_FIN: if (w_ok || w_tout) w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    w_we   = 1'b0;
    w_rd   = 1'b0;
    w_addr = r_addr;
    w_din  = r_din;
    w_cfg  = r_cfg;
    case (r_state)
      S_W0: if (w_ok) begin w_we = 1'b1; w_addr = 27'h4000000; w_din = 16'd3128;  end
      S_W1: if (w_ok) begin w_we = 1'b1; w_addr = 27'h2000000; w_din = 16'd2064;  end
      S_W2: if (w_ok) begin w_we = 1'b1; w_addr = 27'h0000000; w_din = 16'd1032;  end
      S_W3: if (w_ok) begin w_we = 1'b1; w_addr = 27'h1000000; w_din = 16'd12345; end
      S_R0: if (w_ok) begin w_rd = 1'b1; w_addr = 27'h4000000; end
      S_R1: if (w_ok) begin
        w_rd     = 1'b1;
        w_addr   = 27'h2000000;
        w_cfg[2] = (i_sd_dout == 16'd3128);
      end
      S_R2: if (w_ok) begin
        w_rd     = 1'b1;
        w_addr   = 27'h0000000;
        w_cfg[1] = (i_sd_dout == 16'd2064);
      end
      S_FIN: if (w_ok) begin
        w_cfg[0]  = (i_sd_dout == 16'd1032);
        w_cfg[15] = 1'b1;
      end
      S_FILL: if (w_fill_wr) begin
        w_we   = 1'b1;
        w_addr = 27'(r_faddr);
        w_din  = 16'd0;
      end
      default: ;
    endcase
    if (w_tout) begin
      w_cfg[2:0] = 3'b000;
      w_cfg[14]  = 1'b1;
      w_cfg[15]  = 1'b1;
    end
  end

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_we    <= 1'b0;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_cfg   <= '0;
      r_wrap  <= 1'b0;
      r_pass  <= 1'b0;
      r_cnt   <= '0;
      r_faddr <= '0;
      r_tcnt  <= '0;
    end else begin
      r_we   <= w_we;
      r_rd   <= w_rd;
      r_addr <= w_addr;
      r_din  <= w_din;
      r_cfg  <= w_cfg;
      r_cnt  <= r_cnt + c_GAP_W'(1);
      if (w_fill_wr) r_faddr <= r_faddr + CLR_AW'(1);
      // Wrap flag rides with the strobe; the pulse lands one cycle later.
      r_wrap <= w_fill_wr && (&r_faddr);
      r_pass <= r_wrap;
      if (!w_probe || w_ok) r_tcnt <= '0;
      else if (w_wait)      r_tcnt <= r_tcnt + c_TO_W'(1);
    end
  end

  assign o_sd_we     = r_we;
  assign o_sd_rd     = r_rd;
  assign o_sd_addr   = r_addr;
  assign o_sd_din    = r_din;
  assign o_cfg       = r_cfg;
  assign o_pass_done = r_pass;

endmodule

`default_nettype wire

// File: tb/tb_sdram_size_probe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_size_probe
//  Brief    : Randomized bench with an aliasing SDRAM model and a step-list
//             reference of the probe/fill command stream.
//  Revision : 1.0
// ============================================================================

module tb_sdram_size_probe;

  localparam int AW  = 4;
  localparam int GAP = 4;
  localparam int TO  = 4095;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        ready = 1'b0;
  logic [15:0] dout  = '0;
  logic [26:0] sd_addr;
  logic [15:0] sd_din;
  logic        sd_we;
  logic        sd_rd;
  logic [15:0] cfg;
  logic        pass_done;

  always #5 clk = ~clk;

  sdram_size_probe #(.CLR_AW(AW), .CLR_GAP(GAP), .TIMEOUT(TO)) dut (
    .i_clk_sys   (clk),
    .i_reset     (rst),
    .i_sd_ready  (ready),
    .i_sd_dout   (dout),
    .o_sd_addr   (sd_addr),
    .o_sd_din    (sd_din),
    .o_sd_we     (sd_we),
    .o_sd_rd     (sd_rd),
    .o_cfg       (cfg),
    .o_pass_done (pass_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Controller / memory environment
  logic [15:0] mem [int];
  logic [26:0] mask;
  int          mode;      // 0: ready tied high, 1: random latency and drops
  int          lat;
  int          hold;
  bit          stall_after_w2;
  logic [15:0] rdata;

  // Reference model
  int          m_step;    // 0 wait, 1..7 command list, 8 final sample, 9 fill
  int          m_wait;
  int          m_faddr;
  int          m_cnt;
  logic [15:0] m_cfg;
  bit          m_wrap;
  logic        e_we, e_rd, e_pass;
  logic [26:0] e_addr;
  logic [15:0] e_din, e_cfg;
  logic [26:0] t_addr [7];
  logic [15:0] t_data [4];

  int cyc, first_done, we_cnt, pass_cnt, rd_after_abort;

  task automatic model_init();
    m_step = 0; m_wait = 0; m_faddr = 0; m_cnt = 0; m_cfg = '0; m_wrap = 1'b0;
    e_we = 1'b0; e_rd = 1'b0; e_pass = 1'b0; e_addr = '0; e_din = '0; e_cfg = '0;
  endtask

  task automatic model_step(input logic rdy, input logic [15:0] d);
    logic nwe, nrd, nwrap;
    nwe = 1'b0; nrd = 1'b0; nwrap = 1'b0;
    if (m_step == 0) begin
      if (rdy) m_step = 1;
    end else if (m_step <= 8) begin
      if (!(e_we || e_rd)) begin
        if (rdy) begin
          if (m_step >= 6) m_cfg[8 - m_step] = (d == t_data[m_step - 6]);
          if (m_step == 8) begin
            m_cfg[15] = 1'b1;
            m_step = 9;
          end else begin
            if (m_step <= 4) begin
              nwe = 1'b1;
              e_din = t_data[m_step - 1];
            end else begin
              nrd = 1'b1;
            end
            e_addr = t_addr[m_step - 1];
            m_step++;
          end
          m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait == TO) begin
            m_cfg[2:0] = 3'b000;
            m_cfg[15:14] = 2'b11;
            m_step = 9;
          end
        end
      end
    end else begin
      if ((m_cnt % GAP) == GAP - 1 && rdy) begin
        nwe = 1'b1;
        e_addr = 27'(m_faddr);
        e_din = '0;
        nwrap = (m_faddr == (1 << AW) - 1);
        m_faddr = (m_faddr + 1) % (1 << AW);
      end
    end
    m_cnt++;
    e_pass = m_wrap;
    m_wrap = nwrap;
    e_we = nwe;
    e_rd = nrd;
    e_cfg = m_cfg;
  endtask

  task automatic respond();
    int key;
    key = int'(sd_addr & mask);
    if (sd_we || sd_rd) begin
      if (sd_we) begin
        mem[key] = sd_din;
        if (stall_after_w2 && sd_addr == 27'h0 && sd_din == 16'd1032) hold = 4100;
      end else begin
        rdata = mem.exists(key) ? mem[key] : 16'h0;
      end
      lat = (mode == 1) ? int'($urandom_range(0, 3)) : 0;
      // Dead cycle: drive junk that a correct probe must ignore
      ready = (hold > 0) ? 1'b0 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1);
      dout = 16'($urandom);
    end else if (hold > 0) begin
      ready = 1'b0; hold--; dout = 16'($urandom);
    end else if (lat > 0) begin
      ready = 1'b0; lat--; dout = 16'($urandom);
    end else begin
      ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      dout = ready ? rdata : 16'($urandom);
    end
  endtask

  task automatic cycle();
    check("outputs", {sd_we, sd_rd, sd_addr, sd_din, cfg, pass_done},
          {e_we, e_rd, e_addr, e_din, e_cfg, e_pass});
    if (cfg[15] && first_done < 0) first_done = cyc;
    if (sd_we) we_cnt++;
    if (pass_done) pass_cnt++;
    if (cfg[14] && sd_rd) rd_after_abort++;
    respond();
    model_step(ready, dout);
    cyc++;
    @(negedge clk);
  endtask

  task automatic start_run();
    model_init();
    lat = 0; hold = 0; rdata = '0;
    cyc = 0; first_done = -1; we_cnt = 0; pass_cnt = 0; rd_after_abort = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_run();
  endtask

  task automatic run_mask(input logic [26:0] msk, input logic [15:0] exp_cfg, input string name);
    mem.delete(); mask = msk; mode = 1;
    do_reset();
    repeat (300) cycle();
    check(name, cfg, exp_cfg);
  endtask

  initial begin
    bit found;
    t_addr = '{27'h4000000, 27'h2000000, 27'h0000000, 27'h1000000,
               27'h4000000, 27'h2000000, 27'h0000000};
    t_data = '{16'd3128, 16'd2064, 16'd1032, 16'd12345};
    mask = 27'h7FFFFFF; mode = 0; stall_after_w2 = 1'b0;
    model_init();

    // 128MB part, ready tied high
    do_reset();
    repeat (40) cycle();
    check("t1_done_cycle", 64'(first_done), 64'd16);
    check("t1_cfg", cfg, 16'h8007);
    we_cnt = 0; pass_cnt = 0;
    repeat (64) cycle();
    check("t4_fill_writes", 64'(we_cnt), 64'd16);
    check("t4_pass_pulses", 64'(pass_cnt), 64'd1);

    // Aliasing parts with random controller latency and fill-slot drops
    run_mask(27'h0FFFFFF, 16'h8000, "t2_cfg_bits24");
    run_mask(27'h1FFFFFF, 16'h8001, "t2_cfg_bits25");
    run_mask(27'h3FFFFFF, 16'h8003, "cfg_bits26");

    // Ready stuck low after the third write
    mem.delete(); mask = 27'h7FFFFFF; mode = 0; stall_after_w2 = 1'b1;
    do_reset();
    repeat (4300) cycle();
    stall_after_w2 = 1'b0;
    check("t3_cfg", cfg, 16'hC000);
    check("t3_rd_after_abort", 64'(rd_after_abort), 64'd0);
    check("t3_fill_running", 64'(we_cnt > 3), 64'd1);

    // Asynchronous reset while the second read is pending
    mem.delete(); mask = 27'h7FFFFFF; mode = 1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (sd_rd && sd_addr == 27'h4000000) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    check("t6_reach_r1", 64'(found), 64'd1);
    #2 rst = 1'b1;
    #1 check("t6_async_clear", {sd_we, sd_rd, sd_addr, sd_din, cfg, pass_done}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_run();
    repeat (300) cycle();
    check("t6_restart_cfg", cfg, 16'h8007);

    // Random part sizes
    for (int k = 0; k < 3; k++) begin
      case ($urandom_range(0, 3))
        0:       mask = 27'h0FFFFFF;
        1:       mask = 27'h1FFFFFF;
        2:       mask = 27'h3FFFFFF;
        default: mask = 27'h7FFFFFF;
      endcase
      mem.delete(); mode = 1;
      do_reset();
      repeat (300) cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
